// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: sequences a WIDTH-bit addition through an external
// 4-bit combinational adder, one nibble per cycle, chaining the carry and
// assembling a registered WIDTH-bit result with a final carry-out.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             w_accept;
  logic             w_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake outputs; a start in DONE is taken
  // exactly like one in IDLE so operations can run back to back.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    w_last   = (r_idx == IDX_W'(NIBBLES - 1));
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Adder-facing nibbles come straight from the operand shift registers
  // and are forced to zero whenever no nibble is being processed.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = r_a[3:0];
      add_b   = r_b[3:0];
      add_cin = r_carry;
    end
  end

  // Operand capture, per-nibble sum/carry write-back and index advance.
  // Operands shift right so the current nibble is always in bits [3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= op_a;
      r_b      <= op_b;
      r_carry  <= cin;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (r_state == S_RUN) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (r_idx == IDX_W'(n)) begin
          r_result[4*n +: 4] <= add_sum;
        end
      end
      r_carry <= add_cout;
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      if (w_last) begin
        r_cout <= add_cout;
        r_idx  <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;

endmodule
